dcache_core: RTL

DCACHE_CORE -- requirements
Module: dcache_core

---
 rtl/dcache_core.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dcache_core.sv
// Direct-mapped, write-through, no-write-allocate data cache with a Wishbone master port.
// One request outstanding at a time; cache_flush invalidates one line per cycle.
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef RW
`define RW 16
`endif

module dcache_core #(
    parameter int LINES = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [`WB_ADDR_W-1:0] mem_addr,
    input  logic [`RW-1:0]        mem_i_data,
    input  logic [1:0]            mem_sel,
    input  logic                  mem_cache_enable,
    output logic                  mem_ack,
    output logic [`RW-1:0]        mem_o_data,
    output logic                  mem_exception,
    input  logic                  cache_flush,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [`WB_ADDR_W-1:0] wb_adr,
    output logic [`RW-1:0]        wb_o_dat,
    output logic [1:0]            wb_sel,
    input  logic [`RW-1:0]        wb_i_dat,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    output logic [1:0]            dbg_state
);
    localparam int IW = $clog2(LINES);
    localparam int TW = `WB_ADDR_W - IW;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_BUS, S_FLUSH} state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]      valid;
    logic [TW-1:0]         tag_mem  [LINES];
    logic [`RW-1:0]        data_mem [LINES];

    logic                  r_we;
    logic                  r_ce;
    logic [`WB_ADDR_W-1:0] r_addr;
    logic [`RW-1:0]        r_data;
    logic [1:0]            r_sel;
    logic                  pend_req;
    logic                  pend_flush;
    logic [IW-1:0]         flush_idx;

    logic [IW-1:0]         r_idx;
    logic [TW-1:0]         r_tag;
    logic                  hit;
    logic                  flush_go;
    logic                  flush_last;
    logic                  capture;
    logic                  bus_ok;

    assign r_idx      = r_addr[IW-1:0];
    assign r_tag      = r_addr[`WB_ADDR_W-1:IW];
    assign hit        = valid[r_idx] && (tag_mem[r_idx] == r_tag);
    assign flush_go   = cache_flush || pend_flush;
    assign flush_last = (flush_idx == IW'(LINES - 1));
    // A request is only accepted when no other one is held; mem_req elsewhere is ignored.
    assign capture    = mem_req && !pend_req && (state == S_IDLE || state == S_FLUSH);
    assign bus_ok     = (state == S_BUS) && wb_ack && !wb_err;
    assign dbg_state  = state;

    // Handshake: mem_req is a one-cycle strobe; the result is a one-cycle mem_ack or
    // mem_exception pulse. Wishbone holds cyc/stb until the cycle wb_ack or wb_err is seen.
    always_comb begin
        state_nxt     = state;
        mem_ack       = 1'b0;
        mem_exception = 1'b0;
        mem_o_data    = wb_i_dat;
        wb_cyc        = 1'b0;
        wb_stb        = 1'b0;
        wb_we         = r_we;
        wb_adr        = r_addr;
        wb_o_dat      = r_data;
        wb_sel        = r_we ? r_sel : 2'b11;
        case (state)
            S_IDLE: begin
                if (flush_go)     state_nxt = S_FLUSH;
                else if (mem_req) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (!r_we && r_ce && hit) begin
                    mem_ack    = 1'b1;
                    mem_o_data = data_mem[r_idx];
                    state_nxt  = S_IDLE;
                end else begin
                    state_nxt  = S_BUS;
                end
            end
            S_BUS: begin
                wb_cyc = 1'b1;
                wb_stb = 1'b1;
                if (wb_err) begin
                    mem_exception = 1'b1;
                    state_nxt     = S_IDLE;
                end else if (wb_ack) begin
                    mem_ack   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (flush_last) state_nxt = (pend_req || capture) ? S_LOOKUP : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            valid      <= '0;
            pend_req   <= 1'b0;
            pend_flush <= 1'b0;
            flush_idx  <= '0;
            r_we       <= 1'b0;
            r_ce       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_sel      <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                r_we   <= mem_we;
                r_ce   <= mem_cache_enable;
                r_addr <= mem_addr;
                r_data <= mem_i_data;
                r_sel  <= mem_sel;
            end
            if (state_nxt == S_LOOKUP)                    pend_req <= 1'b0;
            else if (capture && state_nxt == S_FLUSH)     pend_req <= 1'b1;
            if (state == S_IDLE)                          pend_flush <= 1'b0;
            else if (cache_flush && (state == S_LOOKUP || state == S_BUS)) pend_flush <= 1'b1;
            if (state == S_FLUSH) begin
                valid[flush_idx] <= 1'b0;
                flush_idx        <= flush_idx + 1'b1;
            end else begin
                flush_idx        <= '0;
            end
            if (bus_ok && !r_we && r_ce) valid[r_idx] <= 1'b1;
        end
    end

    // Tag/data arrays need no reset: valid bits gate every use.
    always_ff @(posedge i_clk) begin
        if (!i_rst && bus_ok) begin
            if (!r_we && r_ce) begin
                tag_mem[r_idx]  <= r_tag;
                data_mem[r_idx] <= wb_i_dat;
            end else if (r_we && hit) begin
                if (r_sel[0]) data_mem[r_idx][7:0]  <= r_data[7:0];
                if (r_sel[1]) data_mem[r_idx][15:8] <= r_data[15:8];
            end
        end
    end
endmodule
